enigma_char_stream: RTL and testbench

Parametrised character streaming stage between the host register interface (UART/register file) and the cipher core. It replaces the single-register, edge-detect new-character scheme with three pieces:
- an input FIFO;
- a sequenced one-character-at-a-time core issue with fixed, configurable core latency;
- an output FIFO.
A bypass mode passes characters through without stepping the core. Sticky status flags and a processed-character counter are provided.

---
 rtl/enigma_char_stream.sv | 186 ++++++++++++++++++
 tb/tb_enigma_char_stream.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/enigma_char_stream.sv
// Character streaming stage between the host register file and the cipher core:
// input FIFO, one-at-a-time core sequencer with fixed latency, output FIFO.

module enigma_char_stream_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;

  // clr empties the FIFO; callers never push in a clr cycle
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

  assign level = wp - rp;
  assign empty = (wp == rp);
  assign full  = (level == (AW+1)'(DEPTH));
  assign dout  = mem[rp[AW-1:0]];
endmodule

module enigma_char_stream #(
  parameter int CHAR_W    = 5,
  parameter int ALPHA     = 26,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16,
  parameter int CORE_LAT  = 2,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_wr,
  input  logic [CHAR_W-1:0]             in_char,
  output logic                          in_full,
  output logic [$clog2(IN_DEPTH):0]     in_level,
  input  logic                          bypass,
  input  logic                          flush,
  input  logic                          clr_status,
  output logic                          core_req,
  output logic [CHAR_W-1:0]             core_char_in,
  input  logic [CHAR_W-1:0]             core_char_out,
  input  logic                          out_rd,
  output logic [CHAR_W-1:0]             out_char,
  output logic                          out_empty,
  output logic [$clog2(OUT_DEPTH):0]    out_level,
  output logic                          busy,
  output logic [CNT_W-1:0]              chars_done,
  output logic                          err_invalid,
  output logic                          err_overflow,
  output logic                          err_underflow
);
  localparam int          LCW     = $clog2(CORE_LAT + 1);
  localparam logic [31:0] ALPHA_U = 32'(ALPHA);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

  state_t             state, state_nxt;
  logic [LCW-1:0]     lat_cnt;
  logic [CHAR_W-1:0]  hold;
  logic               drop_q;
  logic               hold_ld, cap, in_pop, out_push, out_pop, in_push;
  logic               in_empty, out_full;
  logic [CHAR_W-1:0]  in_dout, out_dout;
  logic               char_ok, set_inv, set_ovf, set_unf;

  assign char_ok = (32'(in_char) < ALPHA_U);
  assign set_inv = in_wr && !char_ok;
  assign set_ovf = in_wr && in_full;
  assign set_unf = out_rd && out_empty;
  assign in_push = in_wr && !in_full && char_ok && !flush;
  assign out_pop = out_rd && !out_empty;

  enigma_char_stream_fifo #(.W(CHAR_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk(clk), .reset_n(reset_n), .clr(flush),
    .push(in_push), .pop(in_pop), .din(in_char), .dout(in_dout),
    .full(in_full), .empty(in_empty), .level(in_level)
  );

  enigma_char_stream_fifo #(.W(CHAR_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk(clk), .reset_n(reset_n), .clr(flush),
    .push(out_push), .pop(out_pop), .din(hold), .dout(out_dout),
    .full(out_full), .empty(out_empty), .level(out_level)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Capture lands on the CORE_LAT-th edge after core_req rises
  always_comb begin
    state_nxt = state;
    hold_ld   = 1'b0;
    cap       = 1'b0;
    in_pop    = 1'b0;
    out_push  = 1'b0;
    core_req  = 1'b0;
    case (state)
      IDLE: begin
        if (!in_empty && !out_full && !flush) begin
          in_pop    = 1'b1;
          hold_ld   = 1'b1;
          state_nxt = bypass ? WRITE : ISSUE;
        end
      end
      ISSUE: begin
        core_req = 1'b1;
        if (CORE_LAT == 1) begin
          cap       = 1'b1;
          state_nxt = WRITE;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == LCW'(1)) begin
          cap       = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        out_push  = !(flush || drop_q);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lat_cnt <= '0;
      hold    <= '0;
      drop_q  <= 1'b0;
    end else begin
      if (state == ISSUE)     lat_cnt <= LCW'(CORE_LAT - 1);
      else if (state == WAIT) lat_cnt <= lat_cnt - 1'b1;
      if (hold_ld)  hold <= in_dout;
      else if (cap) hold <= core_char_out;
      // a flush while the core is stepping discards that character's result
      if (state == IDLE) drop_q <= 1'b0;
      else if (flush)    drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chars_done    <= '0;
      err_invalid   <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (clr_status) chars_done <= CNT_W'(out_push);
      else if (out_push) chars_done <= chars_done + 1'b1;
      err_invalid   <= set_inv || (err_invalid   && !clr_status);
      err_overflow  <= set_ovf || (err_overflow  && !clr_status);
      err_underflow <= set_unf || (err_underflow && !clr_status);
    end
  end

  assign core_char_in = (state == ISSUE) ? hold : '0;
  assign out_char     = out_empty ? '0 : out_dout;
  assign busy         = (state != IDLE);
endmodule

// File: tb/tb_enigma_char_stream.sv
// Directed bench for enigma_char_stream with a one-register core model
// returning (char+1) mod 26, i.e. CORE_LAT=2 edges from core_req to capture.

module tb_enigma_char_stream;
  logic        clk = 1'b0;
  logic        reset_n, in_wr, bypass, flush, clr_status, out_rd;
  logic [4:0]  in_char, core_char_out;
  logic        in_full, core_req, out_empty, busy;
  logic        err_invalid, err_overflow, err_underflow;
  logic [4:0]  in_level, out_level;
  logic [4:0]  core_char_in, out_char;
  logic [15:0] chars_done;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int req_cnt   = 0;
  int req_t [8];
  int r0;

  enigma_char_stream #(
    .CHAR_W(5), .ALPHA(26), .IN_DEPTH(16), .OUT_DEPTH(16), .CORE_LAT(2), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_wr(in_wr), .in_char(in_char),
    .in_full(in_full), .in_level(in_level), .bypass(bypass), .flush(flush),
    .clr_status(clr_status), .core_req(core_req), .core_char_in(core_char_in),
    .core_char_out(core_char_out), .out_rd(out_rd), .out_char(out_char),
    .out_empty(out_empty), .out_level(out_level), .busy(busy),
    .chars_done(chars_done), .err_invalid(err_invalid),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_req) begin
      core_char_out      <= 5'((int'(core_char_in) + 1) % 26);
      req_cnt            <= req_cnt + 1;
      req_t[req_cnt % 8] <= cyc;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int c);
    in_wr = 1'b1;
    in_char = 5'(c);
    tick();
    in_wr = 1'b0;
  endtask

  initial begin
    core_char_out = '0;
    reset_n = 1'b0; in_wr = 1'b0; in_char = '0; bypass = 1'b0;
    flush = 1'b0; clr_status = 1'b0; out_rd = 1'b0;
    tick(2);
    chk("rst_busy", busy, 0);
    chk("rst_core_req", core_req, 0);
    chk("rst_core_char_in", core_char_in, 0);
    chk("rst_in_full", in_full, 0);
    chk("rst_out_empty", out_empty, 1);
    chk("rst_levels", {in_level, out_level}, 0);
    chk("rst_out_char", out_char, 0);
    chk("rst_chars_done", chars_done, 0);
    chk("rst_flags", {err_invalid, err_overflow, err_underflow}, 0);
    reset_n = 1'b1;
    tick();

    // cipher mode: 3, 7, 25 -> 4, 8, 0
    push(3); push(7); push(25);
    tick(20);
    chk("cipher_req_cnt", req_cnt, 3);
    chk("cipher_gap1", req_t[1] - req_t[0], 4);
    chk("cipher_gap2", req_t[2] - req_t[1], 4);
    chk("cipher_out_level", out_level, 3);
    chk("cipher_chars_done", chars_done, 3);
    chk("cipher_rd0", out_char, 4);
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    chk("cipher_rd1", out_char, 8);
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    chk("cipher_rd2", out_char, 0);
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    chk("cipher_drained", out_empty, 1);

    // bypass: 10, 11 pass unchanged, no core steps
    bypass = 1'b1;
    in_wr = 1'b1; in_char = 5'd10; tick();
    in_char = 5'd11; tick();
    in_wr = 1'b0; tick();
    chk("byp_first_head", out_char, 10);
    chk("byp_first_level", out_level, 1);
    tick(4);
    chk("byp_level", out_level, 2);
    chk("byp_no_req", req_cnt, 3);
    chk("byp_chars_done", chars_done, 5);
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    chk("byp_rd1", out_char, 11);
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    bypass = 1'b0;

    // out-of-alphabet characters dropped
    push(26); push(31);
    chk("inv_flag", err_invalid, 1);
    chk("inv_level", in_level, 0);
    chk("inv_no_ovf", err_overflow, 0);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    chk("inv_cleared", err_invalid, 0);
    chk("clr_chars_done", chars_done, 0);

    // fill output FIFO via bypass, then stall input and overflow it
    bypass = 1'b1;
    for (int i = 0; i < 16; i++) push(i);
    tick(40);
    chk("fill_out_level", out_level, 16);
    chk("fill_chars_done", chars_done, 16);
    bypass = 1'b0;
    r0 = req_cnt;
    for (int i = 0; i < 16; i++) push(5 + i);
    tick();
    chk("stall_in_full", in_full, 1);
    chk("stall_in_level", in_level, 16);
    chk("stall_idle", busy, 0);
    chk("stall_no_req", req_cnt, r0);
    push(9);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_level", in_level, 16);
    chk("ovf_head", out_char, 0);
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    tick(8);
    chk("resume_one_req", req_cnt, r0 + 1);
    chk("resume_out_level", out_level, 16);
    chk("resume_in_level", in_level, 15);
    chk("resume_chars_done", chars_done, 17);
    chk("resume_head", out_char, 1);

    // flush, refill output, queue 6, release one and flush during WAIT
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_levels", {in_level, out_level}, 0);
    chk("flush_chars_done", chars_done, 17);
    bypass = 1'b1;
    for (int i = 0; i < 16; i++) push(i);
    tick(40);
    bypass = 1'b0;
    for (int i = 1; i <= 6; i++) push(i);
    tick();
    chk("q_in_level", in_level, 6);
    chk("q_chars_done", chars_done, 33);
    r0 = req_cnt;
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    tick();
    chk("fw_issue", core_req, 1);
    chk("fw_core_char_in", core_char_in, 1);
    chk("fw_queued", in_level, 5);
    tick();
    chk("fw_wait_busy", busy, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("fw_levels", {in_level, out_level}, 0);
    tick(3);
    chk("fw_idle", busy, 0);
    chk("fw_req_once", req_cnt, r0 + 1);
    chk("fw_not_written", out_level, 0);
    chk("fw_chars_done", chars_done, 33);

    // underflow, set-wins-over-clear
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    chk("unf_flag", err_underflow, 1);
    out_rd = 1'b1; clr_status = 1'b1; tick(); out_rd = 1'b0;
    chk("unf_set_wins", err_underflow, 1);
    chk("unf_clr_ovf", err_overflow, 0);
    chk("unf_clr_cnt", chars_done, 0);
    tick(); clr_status = 1'b0;
    chk("unf_cleared", err_underflow, 0);

    // reset during WAIT
    push(2);
    tick(2);
    chk("rw_busy", busy, 1);
    reset_n = 1'b0; tick();
    chk("rw_busy0", busy, 0);
    chk("rw_core_req0", core_req, 0);
    chk("rw_levels0", {in_level, out_level}, 0);
    chk("rw_out_empty", out_empty, 1);
    reset_n = 1'b1;
    tick(6);
    chk("rw_nothing_written", out_level, 0);
    chk("rw_chars_done", chars_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
